// File: rtl/fp_mult_pipe_if.sv
// Handshake and data bundle for fp_mult_pipe: operand side (in_*/a/b/rnd/tag_in)
// and result side (out_*/ovf/tag_out). The DUT uses the slave view.
interface fp_mult_pipe_if #(
  parameter int fp_width = 16,
  parameter int TAG_W    = 2
);
  logic                in_valid;
  logic                in_ready;
  logic [fp_width-1:0] a;
  logic [fp_width-1:0] b;
  logic                rnd;
  logic [TAG_W-1:0]    tag_in;
  logic                out_valid;
  logic                out_ready;
  logic [fp_width-1:0] out;
  logic                ovf;
  logic [TAG_W-1:0]    tag_out;

  modport slave (
    input  in_valid, a, b, rnd, tag_in, out_ready,
    output in_ready, out_valid, out, ovf, tag_out
  );

  modport master (
    output in_valid, a, b, rnd, tag_in, out_ready,
    input  in_ready, out_valid, out, ovf, tag_out
  );
endinterface

// File: rtl/fp_mult_pipe.sv
// Pipelined signed fixed-point multiplier with valid/ready flow control, floor or
// round-half-up rounding, overflow flag and tag pass-through. `FP_MULT_SAT_EN clamps on overflow.
module fp_mult_pipe #(
  parameter int fp_width = 16,
  parameter int fp_frac  = 8,
  parameter int STAGES   = 3,
  parameter int TAG_W    = 2
) (
  input  logic          clk,
  input  logic          reset,
  fp_mult_pipe_if.slave bus
);

  localparam int PW = 2 * fp_width;
  localparam logic [PW:0] HALF = (PW+1)'(2 ** (fp_frac - 1));

  logic                 w_adv;
  logic                 w_accept;
  logic signed [PW-1:0] w_a_ext;
  logic signed [PW-1:0] w_b_ext;
  logic signed [PW-1:0] w_prod;

  logic                 w_src_valid;
  logic signed [PW-1:0] w_src_p;
  logic                 w_src_rnd;
  logic [TAG_W-1:0]     w_src_tag;

  logic [PW:0]          w_half;
  logic signed [PW:0]   w_sum;
  logic signed [PW:0]   w_r;
  logic [PW-fp_width+1:0] w_hi;
  logic                 w_ovf;
  logic [fp_width-1:0]  w_res;

  logic                 r_out_valid;
  logic [fp_width-1:0]  r_out;
  logic                 r_ovf;
  logic [TAG_W-1:0]     r_tag_out;

  assign w_adv    = !r_out_valid || bus.out_ready;
  assign w_accept = bus.in_valid && w_adv;

  assign w_a_ext = PW'($signed(bus.a));
  assign w_b_ext = PW'($signed(bus.b));
  assign w_prod  = w_a_ext * w_b_ext;

  // Product is registered in the first stage; rounding and range check sit in
  // front of the output register, so earlier stages only carry the full product.
  generate
    if (STAGES == 1) begin : g_direct
      assign w_src_valid = w_accept;
      assign w_src_p     = w_prod;
      assign w_src_rnd   = bus.rnd;
      assign w_src_tag   = bus.tag_in;
    end else begin : g_mid
      localparam int unsigned MID = STAGES - 1;

      logic                 r_mv [MID];
      logic signed [PW-1:0] r_mp [MID];
      logic                 r_mr [MID];
      logic [TAG_W-1:0]     r_mt [MID];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int unsigned i = 0; i < MID; i++) begin
            r_mv[i] <= 1'b0;
            r_mp[i] <= '0;
            r_mr[i] <= 1'b0;
            r_mt[i] <= '0;
          end
        end else if (w_adv) begin
          r_mv[0] <= w_accept;
          r_mp[0] <= w_prod;
          r_mr[0] <= bus.rnd;
          r_mt[0] <= bus.tag_in;
          for (int unsigned i = 1; i < MID; i++) begin
            r_mv[i] <= r_mv[i-1];
            r_mp[i] <= r_mp[i-1];
            r_mr[i] <= r_mr[i-1];
            r_mt[i] <= r_mt[i-1];
          end
        end
      end

      assign w_src_valid = r_mv[MID-1];
      assign w_src_p     = r_mp[MID-1];
      assign w_src_rnd   = r_mr[MID-1];
      assign w_src_tag   = r_mt[MID-1];
    end
  endgenerate

  // One guard bit keeps P + half from wrapping when P is the most positive product.
  assign w_half = w_src_rnd ? HALF : '0;
  assign w_sum  = {w_src_p[PW-1], w_src_p} + w_half;
  assign w_r    = w_sum >>> fp_frac;

  // Fits iff every bit from the result sign upward matches it.
  assign w_hi  = w_r[PW:fp_width-1];
  assign w_ovf = !((&w_hi) || !(|w_hi));

`ifdef FP_MULT_SAT_EN
  localparam logic [fp_width-1:0] SAT_MAX = {1'b0, {(fp_width-1){1'b1}}};
  localparam logic [fp_width-1:0] SAT_MIN = {1'b1, {(fp_width-1){1'b0}}};

  always_comb begin
    w_res = w_r[fp_width-1:0];
    if (w_ovf) begin
      w_res = w_r[PW] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign w_res = w_r[fp_width-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_ovf       <= 1'b0;
      r_tag_out   <= '0;
    end else if (w_adv) begin
      r_out_valid <= w_src_valid;
      if (w_src_valid) begin
        r_out     <= w_res;
        r_ovf     <= w_ovf;
        r_tag_out <= w_src_tag;
      end
    end
  end

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_out;
  assign bus.ovf       = r_ovf;
  assign bus.tag_out   = r_tag_out;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Self-checking bench for fp_mult_pipe: directed vectors plus randomized traffic
// checked against an arithmetic reference model and an in-order scoreboard.
module tb_fp_mult_pipe;

  localparam int FW = 16;
  localparam int FF = 8;
  localparam int ST = 3;
  localparam int TW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  fp_mult_pipe_if #(.fp_width(FW), .TAG_W(TW)) ifc ();

  fp_mult_pipe #(.fp_width(FW), .fp_frac(FF), .STAGES(ST), .TAG_W(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] out;
    logic          ovf;
    logic [TW-1:0] tag;
    int            cyc;
  } rec_t;

  rec_t exp_q[$];
  rec_t got_q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   rnd_done;

  function automatic rec_t model(logic [FW-1:0] a, logic [FW-1:0] b, logic rnd,
                                 logic [TW-1:0] tag, int c);
    rec_t   e;
    longint p, r, half, maxv, minv;
    p    = longint'($signed(a)) * longint'($signed(b));
    half = rnd ? longint'(2 ** (FF - 1)) : 64'sd0;
    r    = (p + half) >>> FF;
    maxv = longint'(2 ** (FW - 1)) - 1;
    minv = -longint'(2 ** (FW - 1));
    e.ovf = (r > maxv) || (r < minv);
    e.out = r[FW-1:0];
`ifdef FP_MULT_SAT_EN
    if (e.ovf) e.out = (r > 0) ? maxv[FW-1:0] : minv[FW-1:0];
`endif
    e.tag = tag;
    e.cyc = c;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (ifc.in_valid && ifc.in_ready)
        exp_q.push_back(model(ifc.a, ifc.b, ifc.rnd, ifc.tag_in, cyc));
      if (ifc.out_valid && ifc.out_ready)
        got_q.push_back('{ifc.out, ifc.ovf, ifc.tag_out, cyc});
    end
  end

  task automatic flush();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic idle();
    ifc.in_valid = 1'b0;
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one operand pair and holds it until the handshake completes.
  task automatic send(logic [FW-1:0] a, logic [FW-1:0] b, logic rnd, logic [TW-1:0] tag);
    bit acc;
    int n;
    ifc.in_valid = 1'b1;
    ifc.a = a;
    ifc.b = b;
    ifc.rnd = rnd;
    ifc.tag_in = tag;
    n = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = ifc.in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", ifc.in_ready, n);
        acc = 1'b1;
      end
    end
  endtask

  task automatic wait_got(int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic run_one(logic [FW-1:0] a, logic [FW-1:0] b, logic rnd, logic [TW-1:0] tag,
                         output rec_t g, output int lat, output bit ok);
    flush();
    send(a, b, rnd, tag);
    idle();
    wait_got(1, ok);
    g = '{'0, 1'b0, '0, 0};
    lat = -1;
    if (ok && exp_q.size() > 0) begin
      g = got_q[0];
      lat = g.cyc - exp_q[0].cyc;
    end
  endtask

  task automatic test_reset();
    ifc.out_ready = 1'b0;
    step(2);
    n_tests++;
    if ({ifc.out_valid, ifc.out, ifc.ovf, ifc.tag_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b out=%h ovf=%b tag=%h, required all 0",
               ifc.out_valid, ifc.out, ifc.ovf, ifc.tag_out);
    end
    reset = 1'b0;
    step(1);
    n_tests++;
    if (ifc.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 1", ifc.in_ready);
    end
    ifc.out_ready = 1'b1;
  endtask

  task automatic test_basic();
    logic [FW-1:0] va[2];
    logic [FW-1:0] ve[2];
    rec_t g;
    int   lat;
    bit   ok;
    va[0] = 16'h0180; ve[0] = 16'h0240;
    va[1] = 16'hFE80; ve[1] = 16'hFDC0;
    for (int i = 0; i < 2; i++) begin
      run_one(va[i], 16'h0180, 1'b0, 2'd1, g, lat, ok);
      n_tests++;
      if (!ok || g.out !== ve[i] || g.ovf !== 1'b0 || g.tag !== 2'd1) begin
        n_fail++;
        $display("FAIL basic_%0d: got ok=%b out=%h ovf=%b tag=%h, required out=%h ovf=0 tag=1",
                 i, ok, g.out, g.ovf, g.tag, ve[i]);
      end
      n_tests++;
      if (lat !== ST) begin
        n_fail++;
        $display("FAIL basic_latency_%0d: got %0d cycles, required %0d", i, lat, ST);
      end
    end
  endtask

  task automatic test_rounding();
    logic [FW-1:0] va[4];
    logic          vr[4];
    logic [FW-1:0] ve[4];
    rec_t g;
    int   lat;
    bit   ok;
    va[0] = 16'h0001; vr[0] = 1'b0; ve[0] = 16'h0000;
    va[1] = 16'h0001; vr[1] = 1'b1; ve[1] = 16'h0001;
    va[2] = 16'hFFFF; vr[2] = 1'b0; ve[2] = 16'hFFFF;
    va[3] = 16'hFFFF; vr[3] = 1'b1; ve[3] = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      run_one(va[i], 16'h0080, vr[i], 2'(i), g, lat, ok);
      n_tests++;
      if (!ok || g.out !== ve[i] || g.ovf !== 1'b0 || g.tag !== 2'(i)) begin
        n_fail++;
        $display("FAIL round_%0d: got out=%h ovf=%b tag=%h, required out=%h ovf=0 tag=%0d",
                 i, g.out, g.ovf, g.tag, ve[i], i);
      end
    end
  endtask

  task automatic test_overflow();
    logic [FW-1:0] va[2];
    logic [FW-1:0] ve[2];
    rec_t g;
    int   lat;
    bit   ok;
    va[0] = 16'h6400;
    va[1] = 16'h9C00;
`ifdef FP_MULT_SAT_EN
    ve[0] = 16'h7FFF;
    ve[1] = 16'h8000;
`else
    ve[0] = 16'hC800;
    ve[1] = 16'h3800;
`endif
    for (int i = 0; i < 2; i++) begin
      run_one(va[i], 16'h0200, 1'b0, 2'd3, g, lat, ok);
      n_tests++;
      if (!ok || g.out !== ve[i] || g.ovf !== 1'b1) begin
        n_fail++;
        $display("FAIL ovf_%0d: got out=%h ovf=%b, required out=%h ovf=1", i, g.out, g.ovf, ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    flush();
    for (int i = 0; i < 8; i++)
      send(16'($urandom), 16'($urandom), 1'($urandom), 2'(i));
    idle();
    wait_got(8, ok);
    step(3);
    n_tests++;
    if (!ok || got_q.size() != 8 || exp_q.size() != 8) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results / %0d accepts, required 8 / 8",
               got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_tests++;
        if (got_q[i].out !== exp_q[i].out || got_q[i].ovf !== exp_q[i].ovf ||
            got_q[i].tag !== exp_q[i].tag || got_q[i].cyc != got_q[0].cyc + i) begin
          n_fail++;
          $display("FAIL b2b_item_%0d: got out=%h ovf=%b tag=%h cyc=%0d, required out=%h ovf=%b tag=%h cyc=%0d",
                   i, got_q[i].out, got_q[i].ovf, got_q[i].tag, got_q[i].cyc,
                   exp_q[i].out, exp_q[i].ovf, exp_q[i].tag, got_q[0].cyc + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    flush();
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(16'($urandom), 16'($urandom), 1'($urandom), 2'(i % 4));
        idle();
      end
      begin
        logic [FW+TW:0] hold;
        repeat (4) @(posedge clk);
        #1;
        ifc.out_ready = 1'b0;
        @(negedge clk);
        hold = {ifc.out, ifc.ovf, ifc.tag_out};
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          n_tests++;
          if (ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b1 ||
              {ifc.out, ifc.ovf, ifc.tag_out} !== hold) begin
            n_fail++;
            $display("FAIL stall_%0d: got in_ready=%b valid=%b out/ovf/tag=%h, required 0 1 %h",
                     k, ifc.in_ready, ifc.out_valid, {ifc.out, ifc.ovf, ifc.tag_out}, hold);
          end
        end
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b1;
      end
    join
    wait_got(10, ok);
    step(5);
    n_tests++;
    if (!ok || got_q.size() != 10 || exp_q.size() != 10) begin
      n_fail++;
      $display("FAIL bp_count: got %0d results / %0d accepts, required 10 / 10",
               got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_tests++;
        if (got_q[i].out !== exp_q[i].out || got_q[i].ovf !== exp_q[i].ovf ||
            got_q[i].tag !== 2'(i % 4)) begin
          n_fail++;
          $display("FAIL bp_item_%0d: got out=%h ovf=%b tag=%h, required out=%h ovf=%b tag=%0d",
                   i, got_q[i].out, got_q[i].ovf, got_q[i].tag,
                   exp_q[i].out, exp_q[i].ovf, i % 4);
        end
      end
    end
  endtask

  task automatic test_bubbles();
    bit pat[5];
    bit ov[10];
    bit want;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    flush();
    for (int c = 0; c < 10; c++) begin
      ifc.in_valid = (c < 5) ? pat[c] : 1'b0;
      ifc.a = 16'($urandom);
      ifc.b = 16'($urandom);
      ifc.rnd = 1'($urandom);
      ifc.tag_in = 2'(c);
      @(negedge clk);
      ov[c] = ifc.out_valid;
      @(posedge clk);
      #1;
    end
    idle();
    for (int c = 0; c < 10; c++) begin
      want = (c >= 3 && c < 8) ? pat[c-3] : 1'b0;
      n_tests++;
      if (ov[c] !== want) begin
        n_fail++;
        $display("FAIL bubble_valid_%0d: got %b, required %b", c, ov[c], want);
      end
    end
    n_tests++;
    if (got_q.size() != 3 || exp_q.size() != 3 ||
        got_q[0].out !== exp_q[0].out || got_q[2].out !== exp_q[2].out) begin
      n_fail++;
      $display("FAIL bubble_data: got %0d results, required 3 matching the model", got_q.size());
    end
  endtask

  task automatic test_reset_mid();
    rec_t g;
    int   lat;
    bit   ok;
    rec_t e;
    flush();
    for (int i = 0; i < 3; i++)
      send(16'($urandom), 16'($urandom), 1'b0, 2'(i + 1));
    idle();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    n_tests++;
    if ({ifc.out_valid, ifc.out, ifc.ovf, ifc.tag_out} !== '0) begin
      n_fail++;
      $display("FAIL midreset_state: got valid=%b out=%h ovf=%b tag=%h, required all 0",
               ifc.out_valid, ifc.out, ifc.ovf, ifc.tag_out);
    end
    step(6);
    n_tests++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_leak: got %0d stale results, required 0", got_q.size());
    end
    run_one(16'h0300, 16'hFF00, 1'b1, 2'd2, g, lat, ok);
    e = model(16'h0300, 16'hFF00, 1'b1, 2'd2, 0);
    n_tests++;
    if (!ok || g.out !== e.out || g.ovf !== e.ovf || g.tag !== 2'd2 || lat !== ST) begin
      n_fail++;
      $display("FAIL midreset_after: got out=%h ovf=%b tag=%h lat=%0d, required out=%h ovf=%b tag=2 lat=%0d",
               g.out, g.ovf, g.tag, lat, e.out, e.ovf, ST);
    end
  endtask

  task automatic test_random();
    bit ok;
    flush();
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          int gap;
          gap = int'($urandom_range(0, 2));
          if (gap > 0) begin
            idle();
            step(gap);
          end
          send(16'($urandom), 16'($urandom), 1'($urandom), 2'($urandom));
        end
        idle();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          ifc.out_ready = ($urandom_range(0, 3) != 0);
          step(1);
        end
        ifc.out_ready = 1'b1;
      end
    join
    wait_got(200, ok);
    step(5);
    n_tests++;
    if (!ok || got_q.size() != 200 || exp_q.size() != 200) begin
      n_fail++;
      $display("FAIL rnd_count: got %0d results / %0d accepts, required 200 / 200",
               got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 200; i++) begin
        n_tests++;
        if (got_q[i].out !== exp_q[i].out || got_q[i].ovf !== exp_q[i].ovf ||
            got_q[i].tag !== exp_q[i].tag) begin
          n_fail++;
          $display("FAIL rnd_item_%0d: got out=%h ovf=%b tag=%h, required out=%h ovf=%b tag=%h",
                   i, got_q[i].out, got_q[i].ovf, got_q[i].tag,
                   exp_q[i].out, exp_q[i].ovf, exp_q[i].tag);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.a         = '0;
    ifc.b         = '0;
    ifc.rnd       = 1'b0;
    ifc.tag_in    = '0;
    ifc.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_rounding();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
